// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and helpers for the parametrised serial sequence detector.
//   seq_state_t : detector FSM state (FILL while history is too short to
//                 compare, ARMED once it holds len-1 valid bits)
//   MIN_LEN     : smallest legal pattern length
//   clamp_len() : forces a requested length into MIN_LEN..max_w
// -----------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } seq_state_t;

  localparam int unsigned MIN_LEN = 2;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_w);
    if (len < MIN_LEN) begin
      return MIN_LEN;
    end else if (len > max_w) begin
      return max_w;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/param_seq_detector_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; the count sticks at 2^CNT_W-1.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (count -> 0)
//   clr_i  : synchronous clear
//   inc_i  : increment request
//   cnt_o  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/param_seq_detector.sv
// -----------------------------------------------------------------------------
// param_seq_detector
// Run-time configurable serial sequence detector with a saturating match count.
// Build option: SEQ_DET_REG_OUT_EN registers match (one cycle after the final
// bit); undefined gives a zero-latency Mealy match.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid      : qualifies in_bit for this cycle
//   in_bit        : serial data bit
//   cfg_load      : strobe, latches cfg_pattern/cfg_len and restarts detection
//   cfg_pattern   : pattern, bit [len-1] first received, bit [0] last
//   cfg_len       : pattern length, clamped to 2..MAX_W on load
//   cfg_overlap   : 1 = overlapping detection (sampled live)
//   cnt_clr       : synchronous clear of match_cnt
//   match         : detection pulse
//   match_cnt     : saturating detection count
//   armed         : history holds at least len-1 valid bits
//   dbg_state_o   : current FSM state
// Stream handshake: there is no back-pressure; a bit is accepted on every
// rising edge where in_valid is high and cfg_load is low. in_valid low means
// nothing moves and no comparison is made.
// -----------------------------------------------------------------------------
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int MAX_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(MAX_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [MAX_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed,
  output seq_state_t       dbg_state_o
);

  logic [MAX_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [MAX_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  seq_state_t       state_q, state_d;

  logic [MAX_W-1:0] window;
  logic [MAX_W-1:0] len_mask;
  logic [LEN_W-1:0] len_m1;
  logic             match_raw;

  // The candidate occurrence is the stored history followed by today's bit.
  assign window   = {hist_q, in_bit};
  // Low len bits set; len == MAX_W shifts everything out and yields all ones.
  assign len_mask = ~({MAX_W{1'b1}} << len_q);
  assign len_m1   = len_q - LEN_W'(1);

  // A load in the same cycle drops the bit, so it can never produce a match.
  assign match_raw = in_valid && !cfg_load && (state_q == ARMED) &&
                     ((window & len_mask) == (pattern_q & len_mask));

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = LEN_W'(clamp_len(32'(cfg_len), 32'(MAX_W)));
      hist_d    = '0;
      fill_d    = '0;
      state_d   = FILL;
    end else if (in_valid) begin
      if (match_raw && !cfg_overlap) begin
        // Non-overlapping: the matching bit is consumed, start over.
        hist_d  = '0;
        fill_d  = '0;
        state_d = FILL;
      end else begin
        hist_d = window[MAX_W-2:0];
        if (fill_q != len_m1) begin
          fill_d = fill_q + LEN_W'(1);
        end
        if ((state_q == FILL) && (fill_d == len_m1)) begin
          state_d = ARMED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      len_q     <= LEN_W'(MAX_W);
      hist_q    <= '0;
      fill_q    <= '0;
      state_q   <= FILL;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
    end
  end

  // In both builds the count moves on the edge that accepts the final bit,
  // which is also the edge that raises the registered match.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (match_raw),
    .cnt_o (match_cnt)
  );

`ifdef SEQ_DET_REG_OUT_EN
  logic match_q;

  // match_raw is already forced low by cfg_load, so a load also kills any
  // match that would otherwise be pending for the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_raw;
    end
  end

  assign match = match_q;
`else
  assign match = match_raw;
`endif

  assign armed       = (state_q == ARMED);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_param_seq_detector
// Directed scenarios followed by random traffic, checked against a queue-based
// reference model of the detection rules.
// -----------------------------------------------------------------------------
module tb_param_seq_detector;
  import seq_det_pkg::*;

  localparam int MAX_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
  logic [MAX_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;
  seq_state_t       dbg_state;

  param_seq_detector #(
    .MAX_W (MAX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_cnt   (match_cnt),
    .armed       (armed),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [0:0]       bit_q[$];   // accepted bits since last restart, oldest first
  logic [CNT_W-1:0] exp_q[$];   // expected match_cnt after each edge
  logic [MAX_W-1:0] m_pat;
  int               m_len;
  int               m_cnt;
  logic             ovl;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int clamp_m(input int l);
    if (l < 2) return 2;
    if (l > MAX_W) return MAX_W;
    return l;
  endfunction

  // Would the last m_len accepted bits (including b) equal the pattern?
  function automatic logic model_match(input logic b);
    int   n;
    logic x;
    n = bit_q.size();
    if (n < m_len - 1) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      x = (i == 0) ? b : bit_q[n - i][0];
      if (x !== m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    bit_q.delete();
    m_pat = '0;
    m_len = MAX_W;
    m_cnt = 0;
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus; hit returns the DUT's match for this bit.
  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [MAX_W-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic clr, output logic hit);
    logic e;
    @(negedge clk);
    in_valid    = v;
    in_bit      = b;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cnt_clr     = clr;
    e = v && !ld && model_match(b);
    #1;
`ifndef SEQ_DET_REG_OUT_EN
    check("match", match, e);
    hit = match;
`endif
    if (ld) begin
      bit_q.delete();
      m_pat = pat;
      m_len = clamp_m(int'(len));
    end else if (v) begin
      if (e && !ovl) begin
        bit_q.delete();
      end else begin
        bit_q.push_back(b);
        if (bit_q.size() > MAX_W) void'(bit_q.pop_front());
      end
    end
    if (clr) m_cnt = 0;
    else if (e && m_cnt < CMAX) m_cnt++;
    exp_q.push_back(CNT_W'(m_cnt));
    @(posedge clk);
    #1;
`ifdef SEQ_DET_REG_OUT_EN
    check("match", match, e);
    hit = match;
`endif
    check("match_cnt", match_cnt, exp_q.pop_front());
    check("armed", armed, bit_q.size() >= m_len - 1);
  endtask

  task automatic send(input logic b, output logic hit);
    step(1'b1, b, 1'b0, '0, '0, 1'b0, hit);
  endtask

  task automatic idle();
    logic h;
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, h);
  endtask

  task automatic load(input logic [MAX_W-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic clr);
    logic h;
    step(1'b0, 1'b0, 1'b1, pat, len, clr, h);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       h;
    logic [7:0] s8;
    logic [7:0] hits;
    logic       v, b, ld, clr;
    logic [MAX_W-1:0] rp;
    logic [LEN_W-1:0] rl;
    int         r;

    rst_n = 1'b0;
    in_valid = 0; in_bit = 0; cfg_load = 0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 0; cnt_clr = 0; ovl = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_match", match, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_armed", armed, 0);
    check("rst_state", dbg_state, FILL);
    @(negedge clk);
    rst_n = 1'b1;

    // Overlapping 11011 on 11011011: hits on bits 5 and 8.
    ovl = 1'b1;
    load(8'b0001_1011, 4'd5, 1'b1);
    s8 = 8'b1101_1011;
    for (int i = 0; i < 8; i++) begin
      send(s8[7 - i], h);
      hits[i] = h;
    end
    check("ovl_hits", hits, 8'b1001_0000);
    check("ovl_cnt", match_cnt, 2);

    // Same with non-overlap: only bit 5, disarmed after it.
    ovl = 1'b0;
    load(8'b0001_1011, 4'd5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(s8[7 - i], h);
      hits[i] = h;
      if (i == 4) check("novl_armed_after", armed, 0);
    end
    check("novl_hits", hits, 8'b0001_0000);
    check("novl_cnt", match_cnt, 1);

    // 101 with two idle cycles between bits.
    load(8'b0000_0101, 4'd3, 1'b1);
    s8 = 8'b0000_0101;
    hits = '0;
    for (int i = 0; i < 3; i++) begin
      send(s8[2 - i], h);
      hits[i] = h;
      idle();
      idle();
    end
    check("gap_hits", hits, 8'b0000_0100);

    // Load together with a valid bit mid-pattern: the bit is dropped.
    ovl = 1'b1;
    load(8'b0001_1011, 4'd5, 1'b1);
    send(1, h); send(1, h); send(0, h);
    step(1'b1, 1'b1, 1'b1, 8'b0001_1011, 4'd5, 1'b0, h);
    check("load_drop_hit", h, 0);
    send(1, h); check("load_hist_clr_a", h, 0);
    send(1, h); check("load_hist_clr_b", h, 0);
    send(0, h); send(1, h);
    send(1, h); check("load_full_again", h, 1);

    // Saturation at 3 after five matches, then clear beats a match.
    load(8'b0000_0101, 4'd3, 1'b1);
    send(1, h);
    for (int i = 0; i < 5; i++) begin
      send(0, h);
      send(1, h);
    end
    check("sat_cnt", match_cnt, 3);
    send(0, h);
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, h);
    check("clr_hit", h, 1);
    check("clr_wins", match_cnt, 0);

    // Length clamping: 0 -> 2, 15 -> MAX_W.
    load(8'b0000_0010, 4'd0, 1'b1);
    send(1, h);
    send(0, h); check("clamp_lo_hit", h, 1);
    load(8'hA5, 4'd15, 1'b1);
    s8 = 8'hA5;
    hits = '0;
    for (int i = 0; i < 8; i++) begin
      send(s8[7 - i], h);
      hits[i] = h;
    end
    check("clamp_hi_hits", hits, 8'b1000_0000);

    // Asynchronous reset while armed and a matching bit is on the input.
    load(8'b0001_1011, 4'd5, 1'b1);
    send(1, h); send(1, h); send(0, h); send(1, h);
    in_valid = 1'b1; in_bit = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_match", match, 0);
    check("arst_cnt", match_cnt, 0);
    check("arst_armed", armed, 0);
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    load(8'b0001_1011, 4'd5, 1'b0);
    send(1, h); send(1, h);
    check("arst_partial_lost", h, 0);
    send(0, h); send(1, h);
    send(1, h); check("arst_rereceive", h, 1);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      r   = $urandom_range(0, 99);
      ld  = (r < 4);
      clr = (r >= 96);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ovl = ~ovl;
      rp  = MAX_W'($urandom);
      if ($urandom_range(0, 3) == 0) rl = LEN_W'($urandom_range(0, 15));
      else rl = LEN_W'($urandom_range(2, 4));
      step(v, b, ld, rp, rl, clr, h);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
